vga_sync_generator: RTL and testbench

//  Raster timing source for the VGA path. Divides clk_in down to a pixel tick and runs horizontal
//  and vertical counters. Drives current_row/current_line/enable into Module_VGADriver, which

---
 rtl/vga_sync_generator.sv | 150 +++++++++++++++
 tb/tb_vga_sync_generator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_generator.sv
// Raster timing source: clk_in divider, 10-bit row/line counters, registered enable/sync decodes.
// Optional macro VGA_PIPE_ALIGN_EN adds one clk_in stage on enable/hsync/vsync.
module vga_sync_generator #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  output logic [9:0] current_row,
  output logic [9:0] current_line,
  output logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST     = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_generator: H_TOTAL and V_TOTAL must fit 10-bit counters");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_generator: CLK_DIV must be within 1..16");
  end

  logic [3:0] r_div_cnt;
  logic [9:0] r_row;
  logic [9:0] r_line;
  logic       r_enable;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_pix_tick;
  logic       r_line_start;
  logic       r_frame_start;

  logic       w_tick;
  logic [9:0] w_row_nxt;
  logic [9:0] w_line_nxt;
  logic       w_enable;
  logic       w_hsync;
  logic       w_vsync;
  logic       w_row_wrap;

  always_comb begin
    w_tick     = (r_div_cnt == DIV_LAST);
    w_row_wrap = (r_row == H_LAST);
    w_row_nxt  = r_row;
    w_line_nxt = r_line;
    if (w_tick) begin
      if (w_row_wrap) begin
        w_row_nxt  = '0;
        w_line_nxt = (r_line == V_LAST) ? '0 : r_line + 10'd1;
      end else begin
        w_row_nxt = r_row + 10'd1;
      end
    end
  end

  // Decodes come from the next-state coordinates so they line up with the registered counters.
  always_comb begin
    w_enable = ({1'b0, w_row_nxt} < H_ACT_END) && ({1'b0, w_line_nxt} < V_ACT_END);
    w_hsync  = ~SYNC_POL;
    w_vsync  = ~SYNC_POL;
    if (({1'b0, w_row_nxt} >= H_SYNC_START) && ({1'b0, w_row_nxt} < H_SYNC_END)) begin
      w_hsync = SYNC_POL;
    end
    if (({1'b0, w_line_nxt} >= V_SYNC_START) && ({1'b0, w_line_nxt} < V_SYNC_END)) begin
      w_vsync = SYNC_POL;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_div_cnt     <= '0;
      r_row         <= '0;
      r_line        <= '0;
      r_enable      <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_pix_tick    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div_cnt     <= w_tick ? '0 : r_div_cnt + 4'd1;
      r_row         <= w_row_nxt;
      r_line        <= w_line_nxt;
      r_enable      <= w_enable;
      r_hsync       <= w_hsync;
      r_vsync       <= w_vsync;
      r_pix_tick    <= w_tick;
      r_line_start  <= w_tick && (w_row_nxt == '0);
      r_frame_start <= w_tick && (w_row_nxt == '0) && (w_line_nxt == '0);
    end
  end

  assign current_row  = r_row;
  assign current_line = r_line;
  assign pix_tick     = r_pix_tick;
  assign line_start   = r_line_start;
  assign frame_start  = r_frame_start;

`ifdef VGA_PIPE_ALIGN_EN
  // Extra stage matches the downstream registered colour output.
  logic r_enable_d;
  logic r_hsync_d;
  logic r_vsync_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_enable_d <= 1'b0;
      r_hsync_d  <= ~SYNC_POL;
      r_vsync_d  <= ~SYNC_POL;
    end else begin
      r_enable_d <= r_enable;
      r_hsync_d  <= r_hsync;
      r_vsync_d  <= r_vsync;
    end
  end

  assign enable = r_enable_d;
  assign hsync  = r_hsync_d;
  assign vsync  = r_vsync_d;
`else
  assign enable = r_enable;
  assign hsync  = r_hsync;
  assign vsync  = r_vsync;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// Scoreboard bench for vga_sync_generator: two small-raster instances (divided / undivided, both polarities)
// against a time-based arithmetic model, with random reset pulses.
module tb_vga_sync_generator;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DIV_A = 3;
  localparam int DIV_B = 1;
  localparam bit POL_A = 1'b0;
  localparam bit POL_B = 1'b1;
  localparam int N_CYC = 9000;

  typedef struct {
    int row;
    int line;
    bit en;
    bit hs;
    bit vs;
    bit tick;
    bit ls;
    bit fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] row_a, line_a, row_b, line_b;
  logic en_a, hs_a, vs_a, tick_a, ls_a, fs_a;
  logic en_b, hs_b, vs_b, tick_b, ls_b, fs_b;

  vga_sync_generator #(
    .CLK_DIV(DIV_A), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL_A)
  ) u_dut_a (
    .clk_in(clk), .rst_in(rst), .current_row(row_a), .current_line(line_a),
    .enable(en_a), .hsync(hs_a), .vsync(vs_a), .pix_tick(tick_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_sync_generator #(
    .CLK_DIV(DIV_B), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL_B)
  ) u_dut_b (
    .clk_in(clk), .rst_in(rst), .current_row(row_b), .current_line(line_b),
    .enable(en_b), .hsync(hs_b), .vsync(vs_b), .pix_tick(tick_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  bit rst_seen = 1'b0;
  bit done = 1'b0;

  // t = number of clock edges since the edge that sampled reset (0 = the reset edge itself).
  function automatic exp_t calc(int t, int div, bit pol);
    exp_t e;
    int p;
    if (t == 0) begin
      e.row = 0; e.line = 0; e.en = 1'b0; e.hs = ~pol; e.vs = ~pol;
      e.tick = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
      return e;
    end
    p      = t / div;
    e.row  = p % HT;
    e.line = (p / HT) % VT;
    e.tick = (t % div) == 0;
    e.ls   = e.tick && (e.row == 0);
    e.fs   = e.ls && (e.line == 0);
    e.en   = (e.row < HA) && (e.line < VA);
    e.hs   = (e.row >= HA + HF && e.row < HA + HF + HS) ? pol : ~pol;
    e.vs   = (e.line >= VA + VF && e.line < VA + VF + VS) ? pol : ~pol;
    return e;
  endfunction

  function automatic exp_t expect_at(int t, int div, bit pol);
    exp_t e;
    e = calc(t, div, pol);
`ifdef VGA_PIPE_ALIGN_EN
    if (t > 0) begin
      exp_t p;
      p = calc(t - 1, div, pol);
      e.en = p.en;
      e.hs = p.hs;
      e.vs = p.vs;
    end
`endif
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_dut(string tag, exp_t e, int row, int line,
                           bit en, bit hs, bit vs, bit tick, bit ls, bit fs);
    chk({tag, ".row"},         row,  e.row);
    chk({tag, ".line"},        line, e.line);
    chk({tag, ".enable"},      int'(en),   int'(e.en));
    chk({tag, ".hsync"},       int'(hs),   int'(e.hs));
    chk({tag, ".vsync"},       int'(vs),   int'(e.vs));
    chk({tag, ".pix_tick"},    int'(tick), int'(e.tick));
    chk({tag, ".line_start"},  int'(ls),   int'(e.ls));
    chk({tag, ".frame_start"}, int'(fs),   int'(e.fs));
  endtask

  // Stimulus: random reset pulses plus one scripted mid-frame reset; expectation pushed per edge.
  initial begin : driver
    int t;
    int rst_left;
    t = 0;
    rst_left = 0;
    rst = 1'b1;
    rst_seen = 1'b1;
    q_a.push_back(expect_at(0, DIV_A, POL_A));
    q_b.push_back(expect_at(0, DIV_B, POL_B));
    for (int c = 1; c < N_CYC; c++) begin
      @(posedge clk);
      #2;
      if (c == 2000) rst_left = 1;
      else if (rst_left == 0 && c > 10 && $urandom_range(0, 2499) == 0) rst_left = $urandom_range(1, 3);
      rst = (c < 3) || (rst_left > 0);
      if (rst_left > 0) rst_left--;
      if (rst) begin
        t = 0;
        rst_seen = 1'b1;
      end else begin
        t = t + 1;
      end
      q_a.push_back(expect_at(t, DIV_A, POL_A));
      q_b.push_back(expect_at(t, DIV_B, POL_B));
    end
    repeat (3) @(negedge clk);
    #1;
    done = 1'b1;
    chk("drain.q_a", q_a.size(), 0);
    chk("drain.q_b", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Monitor: compare each registered edge's outputs against the queued expectation.
  initial begin : monitor
    exp_t e;
    int last_fs;
    last_fs = -1;
    forever begin
      @(negedge clk);
      if (done) break;
      cyc++;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check_dut("A", e, int'(row_a), int'(line_a), en_a, hs_a, vs_a, tick_a, ls_a, fs_a);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check_dut("B", e, int'(row_b), int'(line_b), en_b, hs_b, vs_b, tick_b, ls_b, fs_b);
      end
      // Independent frame-period measurement on the undivided instance.
      if (fs_b === 1'b1) begin
        if (last_fs >= 0) chk("B.frame_period", cyc - last_fs, HT * VT * DIV_B);
        last_fs = cyc;
      end
      if (rst_seen) begin
        last_fs = -1;
        rst_seen = 1'b0;
      end
    end
  end

endmodule
